// File: rtl/day01_cmd_sequencer.sv
// ASCII command parser for the day01 dial core: turns "L68\nR48\n" into {dir, steps} handshakes.
// Optional `DAY01_CRLF_EN: accept and ignore '\r' so CRLF-terminated input parses cleanly.
module day01_cmd_sequencer #(
  parameter int unsigned STEP_W = 32,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              cmd_valid,
  output logic              cmd_dir,
  output logic [STEP_W-1:0] cmd_steps,
  input  logic              cmd_ready,
  output logic [CNT_W-1:0]  cmd_count,
  output logic              ovf,
  output logic              err,
  output logic              done
);

`ifdef DAY01_CRLF_EN
  localparam bit CRLF_EN = 1'b1;
`else
  localparam bit CRLF_EN = 1'b0;
`endif

  typedef enum logic [2:0] {S_DIR, S_DIGIT, S_EMIT, S_DRAIN, S_DONE, S_ERR} state_e;

  state_e              state_q, state_d;
  logic [STEP_W-1:0]   acc_q, acc_d;
  logic                ndig_q, ndig_d;
  logic                last_q, last_d;
  logic                dir_q, dir_d;
  logic [STEP_W-1:0]   steps_q, steps_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic                in_ready_q, cmd_valid_q, done_q, err_q;

  logic                take, is_digit, is_lf, is_cr, is_dir, sat;
  logic [STEP_W+3:0]   prod;
  logic [STEP_W-1:0]   acc_nxt;

  assign take     = in_valid && in_ready_q;
  assign is_digit = (in_data >= 8'h30) && (in_data <= 8'h39);
  assign is_lf    = (in_data == 8'h0A);
  assign is_cr    = CRLF_EN && (in_data == 8'h0D);
  assign is_dir   = (in_data == 8'h4C) || (in_data == 8'h52);

  // acc*10 + digit fits in STEP_W+4 bits; any carry above STEP_W means saturation.
  assign prod    = ({4'b0000, acc_q} << 3) + ({4'b0000, acc_q} << 1)
                 + {{STEP_W{1'b0}}, in_data[3:0]};
  assign sat     = |prod[STEP_W+3:STEP_W];
  assign acc_nxt = sat ? '1 : prod[STEP_W-1:0];

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ndig_d  = ndig_q;
    last_d  = last_q;
    dir_d   = dir_q;
    steps_d = steps_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_DIR: begin
        if (take) begin
          if (is_dir && !in_last) begin
            dir_d   = (in_data == 8'h52);
            acc_d   = '0;
            ndig_d  = 1'b0;
            last_d  = 1'b0;
            state_d = S_DIGIT;
          end else if (is_lf || is_cr) begin
            if (in_last) state_d = S_DRAIN;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_DIGIT: begin
        if (take) begin
          if (is_digit) begin
            acc_d  = acc_nxt;
            ndig_d = 1'b1;
            if (sat) ovf_d = 1'b1;
            if (in_last) begin
              last_d  = 1'b1;
              steps_d = acc_nxt;
              state_d = S_EMIT;
            end
          end else if (is_lf || (is_cr && in_last)) begin
            if (ndig_q) begin
              last_d  = in_last;
              steps_d = acc_q;
              state_d = S_EMIT;
            end else begin
              state_d = S_ERR;
            end
          end else if (!is_cr) begin
            state_d = S_ERR;
          end
        end
      end
      S_EMIT: begin
        if (cmd_ready) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = last_q ? S_DRAIN : S_DIR;
        end
      end
      S_DRAIN: begin
        if (cmd_ready) state_d = S_DONE;
      end
      default: state_d = state_q;
    endcase
  end

  // Handshake/status outputs are registered from the next state so they change with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_DIR;
      acc_q       <= '0;
      ndig_q      <= 1'b0;
      last_q      <= 1'b0;
      dir_q       <= 1'b0;
      steps_q     <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      cmd_valid_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      ndig_q      <= ndig_d;
      last_q      <= last_d;
      dir_q       <= dir_d;
      steps_q     <= steps_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= (state_d == S_DIR) || (state_d == S_DIGIT);
      cmd_valid_q <= (state_d == S_EMIT);
      done_q      <= (state_d == S_DONE);
      err_q       <= (state_d == S_ERR);
    end
  end

  assign in_ready  = in_ready_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_dir   = dir_q;
  assign cmd_steps = steps_q;
  assign cmd_count = cnt_q;
  assign ovf       = ovf_q;
  assign err       = err_q;
  assign done      = done_q;

endmodule

// File: tb/tb_day01_cmd_sequencer.sv
// Self-checking bench for day01_cmd_sequencer: a string-level parser model predicts the command
// list and final flags; a per-cycle monitor checks every transfer and handshake invariant.
module tb_day01_cmd_sequencer;
  localparam int unsigned STEP_W = 32;
  localparam int unsigned CNT_W  = 32;
  localparam longint unsigned MAXV = (64'd1 << STEP_W) - 1;
`ifdef DAY01_CRLF_EN
  localparam bit CRLF = 1'b1;
`else
  localparam bit CRLF = 1'b0;
`endif

  logic              clk = 0, rst = 0;
  logic              in_valid = 0, in_last = 0, cmd_ready = 1;
  logic [7:0]        in_data = '0;
  logic              in_ready, cmd_valid, cmd_dir, ovf, err, done;
  logic [STEP_W-1:0] cmd_steps;
  logic [CNT_W-1:0]  cmd_count;

  day01_cmd_sequencer #(.STEP_W(STEP_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .cmd_valid(cmd_valid), .cmd_dir(cmd_dir), .cmd_steps(cmd_steps),
    .cmd_ready(cmd_ready), .cmd_count(cmd_count), .ovf(ovf), .err(err), .done(done));

  always #5 clk = ~clk;

  typedef struct packed { logic dir; logic [STEP_W-1:0] steps; } cmd_t;

  int   total = 0, bad = 0, cyc = 0;
  bit   mon_en = 0;
  cmd_t expq[$];
  int   xfer[$];
  bit   m_err, m_ovf, m_done;
  int   m_acc, m_ncmd;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Parse the whole stream at once: commands, accepted-byte count, and final flags.
  function automatic void model(input string s, input bit lastf);
    bit inl = 0, dirv = 0, nd = 0, ended = 0;
    longint unsigned a = 0;
    cmd_t c;
    expq.delete();
    m_err = 0; m_ovf = 0; m_acc = 0; m_ncmd = 0;
    for (int i = 0; i < s.len(); i++) begin
      logic [7:0] ch;
      bit lst, cr;
      ch  = s[i];
      lst = lastf && (i == s.len() - 1);
      cr  = CRLF && (ch == 8'h0D);
      m_acc++;
      if (!inl) begin
        if ((ch == 8'h4C || ch == 8'h52) && !lst) begin
          inl = 1; dirv = (ch == 8'h52); a = 0; nd = 0;
        end else if (ch == 8'h0A || cr) begin
          if (lst) ended = 1;
        end else m_err = 1;
      end else if (ch >= 8'h30 && ch <= 8'h39) begin
        a = a * 10 + longint'(ch - 8'h30); nd = 1;
        if (a > MAXV) begin a = MAXV; m_ovf = 1; end
        if (lst) begin
          c.dir = dirv; c.steps = a[STEP_W-1:0]; expq.push_back(c); m_ncmd++; ended = 1;
        end
      end else if (ch == 8'h0A || (cr && lst)) begin
        if (!nd) m_err = 1;
        else begin
          c.dir = dirv; c.steps = a[STEP_W-1:0]; expq.push_back(c); m_ncmd++;
          inl = 0;
          if (lst) ended = 1;
        end
      end else if (!cr) m_err = 1;
      if (m_err || ended) break;
    end
    m_done = ended && !m_err;
  endfunction

  always @(posedge clk) cyc++;

  bit                pv = 0, pdir = 0;
  logic [STEP_W-1:0] psteps = '0;
  always @(negedge clk) begin
    cmd_t c;
    if (rst || !mon_en) pv = 0;
    else begin
      chk("in_ready_with_valid", {63'd0, in_ready && cmd_valid}, 64'd0);
      chk("done_with_err", {63'd0, done && err}, 64'd0);
      if (pv) begin
        chk("hold_valid", {63'd0, cmd_valid}, 64'd1);
        chk("hold_dir", {63'd0, cmd_dir}, {63'd0, pdir});
        chk("hold_steps", 64'(cmd_steps), 64'(psteps));
      end
      if (cmd_valid && cmd_ready) begin
        xfer.push_back(cyc);
        if (expq.size() == 0) chk("unexpected_cmd", 64'd1, 64'd0);
        else begin
          c = expq.pop_front();
          chk("cmd_dir", {63'd0, cmd_dir}, {63'd0, c.dir});
          chk("cmd_steps", 64'(cmd_steps), 64'(c.steps));
        end
      end
      pv = cmd_valid && !cmd_ready; pdir = cmd_dir; psteps = cmd_steps;
    end
  end

  task automatic do_reset();
    mon_en = 0; in_valid = 0; in_last = 0; cmd_ready = 1;
    @(negedge clk); rst = 1;
    @(negedge clk);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_cmd_valid", {63'd0, cmd_valid}, 64'd0);
    chk("rst_cmd_steps", 64'(cmd_steps), 64'd0);
    chk("rst_cmd_count", 64'(cmd_count), 64'd0);
    chk("rst_flags", {60'd0, cmd_dir, ovf, err, done}, 64'd0);
    rst = 0;
    @(negedge clk);
    chk("in_ready_after_rst", {63'd0, in_ready}, 64'd1);
    xfer.delete();
    mon_en = 1;
  endtask

  task automatic drive(input string s, input bit lastf, output int acc);
    acc = 0;
    for (int i = 0; i < s.len(); i++) begin
      int w = 0;
      bit got = 0;
      in_valid = 1; in_data = s[i]; in_last = lastf && (i == s.len() - 1);
      while (!got && w < 30) begin
        if (in_ready) begin @(posedge clk); #1; got = 1; acc++; end
        else begin @(posedge clk); #1; w++; end
      end
      if (!got) break;
    end
    in_valid = 0; in_last = 0;
  endtask

  task automatic ready_ctl(input int hold);
    int w = 0;
    if (hold > 0) begin
      cmd_ready = 0;
      while (!cmd_valid && w < 200) begin @(negedge clk); w++; end
      chk("first_valid_seen", {63'd0, cmd_valid}, 64'd1);
      repeat (hold) @(posedge clk);
      #1 cmd_ready = 1;
    end
  endtask

  task automatic run_case(input string s, input bit lastf, input int hold);
    int acc, w;
    do_reset();
    model(s, lastf);
    fork
      drive(s, lastf, acc);
      ready_ctl(hold);
    join
    w = 0;
    while (!(done || err) && w < 60) begin @(negedge clk); w++; end
    @(negedge clk);
    chk("bytes_accepted", 64'(acc), 64'(m_acc));
    chk("cmd_count", 64'(cmd_count), 64'(m_ncmd));
    chk("err", {63'd0, err}, {63'd0, m_err});
    chk("ovf", {63'd0, ovf}, {63'd0, m_ovf});
    chk("done", {63'd0, done}, {63'd0, m_done});
    chk("cmds_missing", 64'(expq.size()), 64'd0);
    chk("in_ready_end", {63'd0, in_ready}, 64'd0);
  endtask

  initial begin
    // Pin the model against hand-worked answers.
    model("L68\nR48\n", 1);
    chk("model_n1", 64'(expq.size()), 64'd2);
    chk("model_c0", 64'(expq[0]), {31'd0, 1'b0, 32'd68});
    chk("model_c1", 64'(expq[1]), {31'd0, 1'b1, 32'd48});
    model("R99999999999\n", 1);
    chk("model_sat", 64'(expq[0].steps), 64'hFFFF_FFFF);
    chk("model_ovf", {63'd0, m_ovf}, 64'd1);
    model("L1\nX2\n", 1);
    chk("model_err", {62'd0, m_err, m_done}, 64'd2);
    chk("model_err_acc", 64'(m_acc), 64'd4);

    run_case("L68\nR48\n", 1, 0);
    chk("xfer_n", 64'(xfer.size()), 64'd2);
    if (xfer.size() == 2) chk("cmd_rate", 64'(xfer[1] - xfer[0]), 64'd5);
    run_case("R5", 1, 0);
    run_case("L7\n\nR3\n", 1, 10);
    run_case("R99999999999\n", 1, 0);
    run_case("L1\nX2\n", 1, 0);
    run_case("R12\r\n", 1, 0);
    run_case("R0\nL4294967295\n", 1, 0);
    run_case("\nL10\n", 1, 3);

    // Asynchronous reset while a command is pending.
    do_reset();
    mon_en = 0; cmd_ready = 0;
    begin
      int acc;
      drive("R12\n", 0, acc);
    end
    @(negedge clk);
    chk("pre_rst_valid", {63'd0, cmd_valid}, 64'd1);
    chk("pre_rst_steps", 64'(cmd_steps), 64'd12);
    rst = 1;
    #1;
    chk("async_rst_valid", {63'd0, cmd_valid}, 64'd0);
    chk("async_rst_outs", {60'd0, in_ready, cmd_dir, done, err}, 64'd0);
    chk("async_rst_steps", 64'(cmd_steps), 64'd0);
    @(negedge clk); rst = 0; cmd_ready = 1;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/day01_cmd_sequencer.md
Name: day01_cmd_sequencer

Overview:
Front-end controller for the day01 dial core. It consumes the raw puzzle input as an ASCII byte stream, e.g. "L68\nR48\n". It parses each line into a rotation command {dir, steps} and issues the commands one at a time to the dial core's valid/ready interface. When the stream is exhausted and the dial core has gone idle, it asserts done, replacing the file-reading loop in hardware runs.

Parameters:
STEP_W, 32, width of the steps accumulator and cmd_steps; the accumulator saturates at 2^STEP_W-1.
CNT_W, 32, width of cmd_count.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  in_data holds a valid byte
in_data  input  8  ASCII input byte
in_last  input  1  qualifies in_valid; marks the final byte of the stream
in_ready  output  1  the sequencer accepts a byte this cycle
cmd_valid  output  1  a command is presented to the dial core
cmd_dir  output  1  1 = R, 0 = L
cmd_steps  output  STEP_W  rotation magnitude
cmd_ready  input  1  dial core ready; a command transfers when cmd_valid and cmd_ready are both high
cmd_count  output  CNT_W  number of commands transferred
ovf  output  1  sticky; set when any steps value saturated
err  output  1  sticky syntax error
done  output  1  sticky; the stream is fully consumed and the dial core is idle

Behaviour:
- Reset values: all outputs 0, state S_DIR, accumulator 0. in_ready rises the first cycle after rst deasserts.
- A byte is accepted when in_valid and in_ready are both high. in_ready = 1 only in S_DIR and S_DIGIT.
- S_DIR:
  - 'L' or 'R': latch dir, clear acc and ndig, go to S_DIGIT.
  - '\n': ignored (blank line). If in_last is also set, go to S_DRAIN.
  - Any other byte: go to S_ERR.
- S_DIGIT:
  - '0'..'9': acc = acc*10 + digit, ndig++. If the result exceeds 2^STEP_W-1, acc becomes all-ones and ovf is set.
  - '\n' with ndig > 0: go to S_EMIT.
  - Digit with in_last set: accept the digit, set last_pend, go to S_EMIT (supports files without a trailing newline).
  - '\n' with ndig == 0, or any non-digit byte: go to S_ERR.
  - '\n' with in_last set: set last_pend.
- S_EMIT:
  - cmd_valid = 1; cmd_dir and cmd_steps are registered and held stable until transfer.
  - On transfer: cmd_count++, then go to S_DRAIN if last_pend, otherwise S_DIR.
- S_DRAIN: wait for cmd_ready = 1 (dial core has finished its last rotation), then go to S_DONE.
- S_DONE: done = 1, in_ready = 0. Stays here until reset.
- S_ERR: err = 1, in_ready = 0, cmd_valid = 0. Stays here until reset. A command already transferred is not retracted.
- Latency: a terminating byte accepted in cycle N gives cmd_valid = 1 in cycle N+1. With cmd_ready held high, the sustained rate is one command per (line length + 1) cycles.
- cmd_valid never drops without a transfer. cmd_dir and cmd_steps never change while cmd_valid = 1 and cmd_ready = 0.
- The cmd_count increment wraps modulo 2^CNT_W.
- Asynchronous reset mid-command: all state is cleared immediately and cmd_valid drops. The upstream source must restart the stream.
- in_last on a byte that causes an error: err takes priority; done is never asserted.
- ovf and err can both be set; done and err are never both set.

Optional Feature:
DAY01_CRLF_EN.
- Defined: '\r' is accepted and ignored in S_DIR and S_DIGIT, so "R12\r\n" parses as R12.
- Undefined: '\r' is a syntax error and the block goes to S_ERR.

Test Plan:
1. Stream "L68\nR48\n" (in_last on the final '\n'), cmd_ready = 1 → commands (0,68) then (1,48); cmd_count = 2; done = 1; err = 0.
2. Stream "R5" (in_last on '5') → one command (1,5); done after cmd_ready; cmd_count = 1.
3. Stream "L7\n\nR3\n" with cmd_ready held low for 10 cycles after the first cmd_valid → cmd_valid and (0,7) are held, in_ready = 0 throughout; after release, (1,3) is issued; no command is lost.
4. Stream "R99999999999\n" → cmd_steps = 0xFFFFFFFF, ovf = 1, err = 0.
5. Stream "L1\nX2\n" → (0,1) is issued, then err = 1, in_ready = 0, and done stays 0. Asserting rst mid-stream on "R12" → all outputs return to 0 the same cycle.
6. Stream "R12\r\n" → with DAY01_CRLF_EN: command (1,12). Without it: err = 1.
